// File: rtl/obstacle_field_if.sv
// Bundles the game-step inputs and the obstacle/score outputs of obstacle_field.
// master = tick source / display side, slave = the obstacle engine.
interface obstacle_field_if #(
   parameter int unsigned NUM_OBS = 4,
   parameter int unsigned SCORE_W = 8
);
   logic                   tick;
   logic                   start;
   logic                   difficulty;
   logic [9:0]             plane_y;
   logic [NUM_OBS*10-1:0]  obs_x;
   logic [NUM_OBS*10-1:0]  obs_gap_y;
   logic [NUM_OBS-1:0]     obs_active;
   logic                   running;
   logic                   game_over;
   logic [SCORE_W-1:0]     score;

   modport master (
      output tick, start, difficulty, plane_y,
      input  obs_x, obs_gap_y, obs_active, running, game_over, score
   );

   modport slave (
      input  tick, start, difficulty, plane_y,
      output obs_x, obs_gap_y, obs_active, running, game_over, score
   );
endinterface

// File: rtl/obstacle_field.sv
// N-channel obstacle engine: scrolling, LFSR gap placement, spawn scheduling, collision, scoring, FSM.
// Optional macro OBS_SPEEDUP_EN: speed grows with score (base + score/16, capped at 2*base).
module obstacle_field #(
   parameter int unsigned NUM_OBS    = 4,
   parameter int unsigned SCREEN_W   = 640,
   parameter int unsigned OBS_W      = 40,
   parameter int unsigned GAP_H      = 120,
   parameter int unsigned PLANE_X    = 100,
   parameter int unsigned PLANE_W    = 32,
   parameter int unsigned PLANE_H    = 20,
   parameter int unsigned SPAWN_GAP  = 60,
   parameter int unsigned SPEED_SLOW = 2,
   parameter int unsigned SPEED_FAST = 4,
   parameter int unsigned SCORE_W    = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input logic             clk,
   input logic             reset,
   obstacle_field_if.slave bus
);

   localparam int unsigned          CntW     = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam logic [CntW-1:0]      CntLast  = CntW'(SPAWN_GAP - 1);
   localparam logic [SCORE_W-1:0]   ScoreMax = '1;
   localparam logic [NUM_OBS-1:0]   ObsOne   = NUM_OBS'(1);

   typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

   state_e              state_q, state_d;
   logic [9:0]          x_q   [NUM_OBS];
   logic [9:0]          x_d   [NUM_OBS];
   logic [9:0]          gap_q [NUM_OBS];
   logic [9:0]          gap_d [NUM_OBS];
   logic [NUM_OBS-1:0]  active_q, active_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic                start_low_q, start_low_d;
   logic                running_q, running_d;
   logic                game_over_q, game_over_d;

   logic [NUM_OBS-1:0]  hit;
   logic [NUM_OBS-1:0]  retire;
   logic [NUM_OBS-1:0]  free_ch;
   logic [NUM_OBS-1:0]  spawn_oh;
   logic                crash;
   logic [10:0]         base_spd;
   logic [10:0]         spd;
   logic [3:0]          ret_cnt;
   logic [SCORE_W+3:0]  score_sum;
   logic [SCORE_W-1:0]  score_sat;

   // Overlap of [x, x+OBS_W) with the plane span, outside the vertical gap; 11-bit compares.
   always_comb begin
      for (int i = 0; i < NUM_OBS; i++) begin
         hit[i] = active_q[i]
            && ({1'b0, x_q[i]} < 11'(PLANE_X + PLANE_W))
            && (({1'b0, x_q[i]} + 11'(OBS_W)) > 11'(PLANE_X))
            && !(({1'b0, bus.plane_y} >= {1'b0, gap_q[i]})
                 && (({1'b0, bus.plane_y} + 11'(PLANE_H))
                     <= ({1'b0, gap_q[i]} + 11'(GAP_H))));
      end
   end

   assign crash    = (state_q == StRun) && (|hit);
   assign base_spd = bus.difficulty ? 11'(SPEED_FAST) : 11'(SPEED_SLOW);

`ifdef OBS_SPEEDUP_EN
   logic [10:0] boost_spd;
   assign boost_spd = base_spd + 11'(score_q >> 4);
   assign spd       = (boost_spd > (base_spd << 1)) ? (base_spd << 1) : boost_spd;
`else
   assign spd = base_spd;
`endif

   always_comb begin
      ret_cnt = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         retire[i] = active_q[i] && ({1'b0, x_q[i]} < spd);
         ret_cnt   = ret_cnt + 4'(retire[i]);
      end
   end

   assign score_sum = {4'b0000, score_q} + {{SCORE_W{1'b0}}, ret_cnt};
   assign score_sat = (score_sum > {4'b0000, ScoreMax}) ? ScoreMax : score_sum[SCORE_W-1:0];

   // Lowest free channel, judged on pre-tick occupancy so a retiring slot waits a tick.
   assign free_ch  = ~active_q;
   assign spawn_oh = free_ch & (~free_ch + ObsOne);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      gap_d       = gap_q;
      active_d    = active_q;
      score_d     = score_q;
      cnt_d       = cnt_q;
      start_low_d = start_low_q;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d  = StRun;
               active_d = '0;
               score_d  = '0;
               cnt_d    = CntLast;
               for (int i = 0; i < NUM_OBS; i++) begin
                  x_d[i]   = '0;
                  gap_d[i] = '0;
               end
            end
         end
         StRun: begin
            start_low_d = 1'b0;
            if (crash) begin
               state_d = StOver;
            end else if (bus.tick) begin
               for (int i = 0; i < NUM_OBS; i++) begin
                  if (retire[i]) begin
                     active_d[i] = 1'b0;
                  end else if (active_q[i]) begin
                     x_d[i] = x_q[i] - spd[9:0];
                  end
               end
               score_d = score_sat;
               if (cnt_q == CntLast) begin
                  if (|free_ch) begin
                     cnt_d = '0;
                     for (int i = 0; i < NUM_OBS; i++) begin
                        if (spawn_oh[i]) begin
                           x_d[i]      = 10'(SCREEN_W);
                           gap_d[i]    = 10'd16 + {2'b00, lfsr_q[7:0]};
                           active_d[i] = 1'b1;
                        end
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StOver: begin
            // Leave only on a fresh press: start must be seen low while in OVER first.
            if (!bus.start) begin
               start_low_d = 1'b1;
            end else if (start_low_q) begin
               state_d     = StIdle;
               start_low_d = 1'b0;
               active_d    = '0;
               score_d     = '0;
               for (int i = 0; i < NUM_OBS; i++) begin
                  x_d[i]   = '0;
                  gap_d[i] = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      running_d   = (state_d == StRun);
      game_over_d = (state_d == StOver);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         active_q    <= '0;
         score_q     <= '0;
         cnt_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         start_low_q <= 1'b0;
         running_q   <= 1'b0;
         game_over_q <= 1'b0;
         for (int i = 0; i < NUM_OBS; i++) begin
            x_q[i]   <= '0;
            gap_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         score_q     <= score_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         start_low_q <= start_low_d;
         running_q   <= running_d;
         game_over_q <= game_over_d;
         for (int i = 0; i < NUM_OBS; i++) begin
            x_q[i]   <= x_d[i];
            gap_q[i] <= gap_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
      assign bus.obs_x[10*g +: 10]     = x_q[g];
      assign bus.obs_gap_y[10*g +: 10] = gap_q[g];
   end

   assign bus.obs_active = active_q;
   assign bus.running    = running_q;
   assign bus.game_over  = game_over_q;
   assign bus.score      = score_q;

endmodule
